add_accumulator: RTL
====================

// Module: add_accumulator
// PURPOSE
//  Streaming accumulator that sits directly downstream of the 16-bit ripple adder datapath.
//  Consumes a frame of operand words over a valid/ready handshake and adds each word into a running sum.
//  The adder is a chain of 4-bit carry slices with cin tied 0.
//  At the frame's last word it presents the final sum, a sticky carry flag and a word count on an output handshake.
//  Used to reduce operand streams, e.g. checksums and totals, before write-back.
// PARAMETERS
//  WIDTH  16  data/accumulator width; must be a multiple of 4 (one 4-bit slice per nibble)
//  CNT_W  8   width of the per-frame word counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        upstream word valid
//  in_ready   out  1        block can accept a word this cycle
//  in_data    in   WIDTH    operand word
//  in_last    in   1        qualifies in_data as last word of frame
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  WIDTH    frame sum modulo 2^WIDTH
//  out_carry  out  1        1 if any add in the frame carried out of bit WIDTH-1
//  out_count  out  CNT_W    words in frame, saturating at 2^CNT_W-1
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert use): state=ACC, acc=0, carry=0, count=0,
//    out_valid=0, out_sum=0, out_carry=0, out_count=0; in_ready=0 while rst high.
//  - States: ACC (collecting), HOLD (result presented). in_ready = (state==ACC) & !rst, no comb path from out_ready.
//  - ACC, in_valid&in_ready, in_last=0: {c,acc} <= acc+in_data; carry <= carry|c; count <= sat(count+1).
//  - ACC, handshake with in_last=1: out_sum <= acc+in_data; out_carry <= carry|c;
//    out_count <= sat(count+1); out_valid <= 1; state -> HOLD. Latency: out_valid 1 cycle after last handshake.
//  - Same cycle, acc/carry/count clear to 0 (ready for next frame).
//  - HOLD: in_ready=0; out_sum/out_carry/out_count/out_valid held stable until out_valid&out_ready.
//  - HOLD, out_ready=1: out_valid <= 0, state -> ACC; in_ready=1 next cycle.
//    Min frame-to-frame gap: one cycle. out_* data values may remain stale after handshake.
//  - in_valid low in ACC: no state change; gaps inside a frame are legal.
//  - Sum wraps modulo 2^WIDTH; carry is sticky per frame, never cleared mid-frame.
//  - count saturates at all-ones; further words still summed.
//  - Single-word frame (in_last on first beat): sum=in_data, carry=0, count=1.
//  - Reset mid-frame or in HOLD: partial frame/result discarded, all state per reset values, out_valid drops immediately.
//  - in_data/in_last ignored when no handshake; X on them with in_valid=0 must not corrupt state.
// TESTING
//  1 Reset: assert rst mid-run -> out_valid=0, out_sum=0, out_count=0, in_ready=0 while rst high.
//  2 Frame 0x0001,0x0002,0x0003(last) -> next cycle out_valid=1, out_sum=0x0006, out_carry=0, out_count=3.
//  3 Wrap: 0xFFFF,0x0002(last) -> out_sum=0x0001, out_carry=1, out_count=2;
//    next frame 0x0001(last) -> carry=0.
//  4 Backpressure: out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0, held in_valid word not consumed;
//    out_ready=1 -> word accepted cycle after.
//  5 Back-to-back single-word frames 0x1234(last), 0x00FF(last), out_ready=1 -> results 0x1234 then 0x00FF, count=1 each.
//  6 CNT_W=2: 5-word frame of 0x0001 -> out_count=3 (saturated), out_sum=0x0005;
//    reset after 2 words then 0x0005(last) -> out_sum=0x0005.

Source files
------------

// File: rtl/add_accumulator.sv
// Frame accumulator behind the 16-bit ripple adder datapath.
// Sums a handshaked word stream and presents sum, sticky carry and count.
module add_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             take;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = (state_q == ACC) & ~rst;
  assign take     = in_valid & in_ready;

  // Chain of 4-bit carry slices, carry-in of the first slice tied low.
  always_comb begin
    logic [4:0] s;
    logic       c;
    sum = '0;
    s   = '0;
    c   = 1'b0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      s = {1'b0, acc_q[4*i +: 4]}
        + {1'b0, in_data[4*i +: 4]}
        + {4'b0, c};
      sum[4*i +: 4] = s[3:0];
      c = s[4];
    end
    cout = c;
  end

  assign cnt_inc = (count_q == '1) ? count_q
                                   : count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;
    unique case (state_q)
      ACC: begin
        if (take && in_last) begin
          out_sum_d   = sum;
          out_carry_d = carry_q | cout;
          out_count_d = cnt_inc;
          out_valid_d = 1'b1;
          acc_d       = '0;
          carry_d     = 1'b0;
          count_d     = '0;
          state_d     = HOLD;
        end else if (take) begin
          acc_d   = sum;
          carry_d = carry_q | cout;
          count_d = cnt_inc;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_count = out_count_q;

endmodule
